// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider issue controller.
package div_ctrl_pkg;

  // Default operand / quotient / remainder width.
  localparam int DATA_W_DEF = 32;

  // Field positions inside a default-width {quot, rem} core result word.
  localparam int QUOT_MSB = 2 * DATA_W_DEF - 1;
  localparam int QUOT_LSB = DATA_W_DEF;
  localparam int REM_MSB  = DATA_W_DEF - 1;
  localparam int REM_LSB  = 0;

  // One-hot controller states.
  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_ISSUE = 5'b00010,
    ST_WAIT  = 5'b00100,
    ST_DONE  = 5'b01000,
    ST_DRAIN = 5'b10000
  } state_e;

endpackage

// File: rtl/axis_src_hold.sv
// One AXI-stream source channel: a pending bit armed by start and retired by
// the handshake, with tvalid gated by the controller's issue window.
module axis_src_hold (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic tready,
  input  logic enable,
  output logic tvalid,
  output logic done
);

  logic pend_q;

  // Pending bit: set when a request is accepted, cleared on this channel's handshake.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    if (reset) begin
      pend_q <= 1'b0;
    end else if (start) begin
      pend_q <= 1'b1;
    end else if (tvalid && tready) begin
      pend_q <= 1'b0;
    end
  end

  // A stale pend bit left by an abandoned request is harmless: enable is low
  // outside the issue window and the next start re-arms it anyway.
  assign tvalid = pend_q & enable;

  // Channel complete, including the cycle in which the handshake happens.
  assign done = !pend_q || (tvalid && tready);

endmodule

// File: rtl/div_issue_ctrl.sv
// Sequencing controller between EX and the signed / unsigned divider cores.
// Issues both operand channels independently, waits for the selected core,
// holds the {quot, rem} result for EX, and abandons or drains on flush.
module div_issue_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_signed,
  input  logic [DATA_W-1:0]   req_src1,
  input  logic [DATA_W-1:0]   req_src2,
  input  logic                flush,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_quot,
  output logic [DATA_W-1:0]   resp_rem,
  output logic                busy,
  output logic [DATA_W-1:0]   s_dvd_tdata,
  output logic [DATA_W-1:0]   s_dvs_tdata,
  output logic                sd_dvd_tvalid,
  input  logic                sd_dvd_tready,
  output logic                sd_dvs_tvalid,
  input  logic                sd_dvs_tready,
  input  logic                sd_dout_tvalid,
  input  logic [2*DATA_W-1:0] sd_dout_tdata,
  output logic                ud_dvd_tvalid,
  input  logic                ud_dvd_tready,
  output logic                ud_dvs_tvalid,
  input  logic                ud_dvs_tready,
  input  logic                ud_dout_tvalid,
  input  logic [2*DATA_W-1:0] ud_dout_tdata
);

  state_e              state_q, state_d;
  logic                sel_signed_q;
  logic                flushed_q;
  logic [DATA_W-1:0]   src1_q, src2_q;
  logic [2*DATA_W-1:0] result_q;

  logic                accept;
  logic                capture;
  logic                issue_en;
  logic                dvd_tvalid, dvs_tvalid;
  logic                dvd_done, dvs_done;
  logic                dvd_tready, dvs_tready;
  logic                dout_tvalid;
  logic [2*DATA_W-1:0] dout_tdata;

  // Route the selected core's handshake inputs; the other core is ignored.
  assign dvd_tready  = sel_signed_q ? sd_dvd_tready  : ud_dvd_tready;
  assign dvs_tready  = sel_signed_q ? sd_dvs_tready  : ud_dvs_tready;
  assign dout_tvalid = sel_signed_q ? sd_dout_tvalid : ud_dout_tvalid;
  assign dout_tdata  = sel_signed_q ? sd_dout_tdata  : ud_dout_tdata;

  assign issue_en = (state_q == ST_ISSUE);
  assign accept   = (state_q == ST_IDLE) && req_valid && !flush;
  assign capture  = (state_q == ST_WAIT) && dout_tvalid && !flush;

  axis_src_hold u_dvd_hold (
    .clk    (clk),
    .reset  (reset),
    .start  (accept),
    .tready (dvd_tready),
    .enable (issue_en),
    .tvalid (dvd_tvalid),
    .done   (dvd_done)
  );

  axis_src_hold u_dvs_hold (
    .clk    (clk),
    .reset  (reset),
    .start  (accept),
    .tready (dvs_tready),
    .enable (issue_en),
    .tvalid (dvs_tvalid),
    .done   (dvs_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && !flush) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // Nothing handed to a core yet: drop the request outright. Once either
        // operand has gone, the other must follow so the core is not stranded.
        if (flush && !dvd_done && !dvs_done) begin
          state_d = ST_IDLE;
        end else if (dvd_done && dvs_done) begin
          state_d = (flushed_q || flush) ? ST_DRAIN : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_d = dout_tvalid ? ST_IDLE : ST_DRAIN;
        end else if (dout_tvalid) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (resp_ready || flush) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (dout_tvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from state plus per-core tvalid routing.
  always_comb begin
    req_ready     = (state_q == ST_IDLE) && !flush;
    busy          = (state_q != ST_IDLE);
    resp_valid    = (state_q == ST_DONE);
    sd_dvd_tvalid = dvd_tvalid &  sel_signed_q;
    sd_dvs_tvalid = dvs_tvalid &  sel_signed_q;
    ud_dvd_tvalid = dvd_tvalid & ~sel_signed_q;
    ud_dvs_tvalid = dvs_tvalid & ~sel_signed_q;
  end

  // Operand, selection, flushed-flag and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      src1_q       <= '0;
      src2_q       <= '0;
      sel_signed_q <= 1'b0;
      flushed_q    <= 1'b0;
      result_q     <= '0;
    end else begin
      if (accept) begin
        src1_q       <= req_src1;
        src2_q       <= req_src2;
        sel_signed_q <= req_signed;
        flushed_q    <= 1'b0;
      end else if (issue_en && flush) begin
        flushed_q    <= 1'b1;
      end
      if (capture) begin
        result_q <= dout_tdata;
      end
    end
  end

  // Operands are held for the whole issue window, so tdata is stable under tvalid.
  assign s_dvd_tdata = src1_q;
  assign s_dvs_tdata = src2_q;
  assign resp_quot   = result_q[2*DATA_W-1:DATA_W];
  assign resp_rem    = result_q[DATA_W-1:0];

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed testbench for div_issue_ctrl; the bench plays both divider cores.
module tb_div_issue_ctrl;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           req_valid, req_ready, req_signed;
  logic [W-1:0]   req_src1, req_src2;
  logic           flush;
  logic           resp_valid, resp_ready;
  logic [W-1:0]   resp_quot, resp_rem;
  logic           busy;
  logic [W-1:0]   s_dvd_tdata, s_dvs_tdata;
  logic           sd_dvd_tvalid, sd_dvd_tready, sd_dvs_tvalid, sd_dvs_tready;
  logic           sd_dout_tvalid;
  logic [2*W-1:0] sd_dout_tdata;
  logic           ud_dvd_tvalid, ud_dvd_tready, ud_dvs_tvalid, ud_dvs_tready;
  logic           ud_dout_tvalid;
  logic [2*W-1:0] ud_dout_tdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_issue_ctrl #(.DATA_W(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_signed     (req_signed),
    .req_src1       (req_src1),
    .req_src2       (req_src2),
    .flush          (flush),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_quot      (resp_quot),
    .resp_rem       (resp_rem),
    .busy           (busy),
    .s_dvd_tdata    (s_dvd_tdata),
    .s_dvs_tdata    (s_dvs_tdata),
    .sd_dvd_tvalid  (sd_dvd_tvalid),
    .sd_dvd_tready  (sd_dvd_tready),
    .sd_dvs_tvalid  (sd_dvs_tvalid),
    .sd_dvs_tready  (sd_dvs_tready),
    .sd_dout_tvalid (sd_dout_tvalid),
    .sd_dout_tdata  (sd_dout_tdata),
    .ud_dvd_tvalid  (ud_dvd_tvalid),
    .ud_dvd_tready  (ud_dvd_tready),
    .ud_dvs_tvalid  (ud_dvs_tvalid),
    .ud_dvs_tready  (ud_dvs_tready),
    .ud_dout_tvalid (ud_dout_tvalid),
    .ud_dout_tdata  (ud_dout_tdata)
  );

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs follow freshly driven inputs before sampling.
  task automatic settle();
    #1;
  endtask

  task automatic issue_req(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid  = 1'b1;
    req_signed = sgn;
    req_src1   = a;
    req_src2   = b;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    settle();
    n_vec++;
    if ({req_ready, busy, resp_valid} !== 3'b100) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 100", {req_ready, busy, resp_valid});
    end
    n_vec++;
    if ({sd_dvd_tvalid, sd_dvs_tvalid, ud_dvd_tvalid, ud_dvs_tvalid} !== 4'b0000) begin
      n_err++; $display("FAIL reset_tvalid: got %b expected 0000",
                        {sd_dvd_tvalid, sd_dvs_tvalid, ud_dvd_tvalid, ud_dvs_tvalid});
    end
    n_vec++;
    if ({resp_quot, resp_rem, s_dvd_tdata, s_dvs_tdata} !== 128'h0) begin
      n_err++; $display("FAIL reset_data: got %h expected 0", {resp_quot, resp_rem, s_dvd_tdata, s_dvs_tdata});
    end
  endtask

  task automatic test_signed();
    issue_req(1'b1, 32'hFFFF_FFF9, 32'd2);
    sd_dvd_tready = 1'b1; sd_dvs_tready = 1'b1;
    ud_dvd_tready = 1'b1; ud_dvs_tready = 1'b1;
    resp_ready = 1'b1;
    settle();
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL signed_req_ready: got %b expected 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
    settle();
    n_vec++;
    if ({sd_dvd_tvalid, sd_dvs_tvalid, ud_dvd_tvalid, ud_dvs_tvalid, busy, req_ready} !== 6'b110010) begin
      n_err++; $display("FAIL signed_issue: got %b expected 110010",
                        {sd_dvd_tvalid, sd_dvs_tvalid, ud_dvd_tvalid, ud_dvs_tvalid, busy, req_ready});
    end
    n_vec++;
    if ({s_dvd_tdata, s_dvs_tdata} !== {32'hFFFF_FFF9, 32'd2}) begin
      n_err++; $display("FAIL signed_tdata: got %h expected fffffff900000002", {s_dvd_tdata, s_dvs_tdata});
    end
    tick();
    for (int c = 0; c < 9; c++) begin
      // A result from the unselected core mid-wait must be ignored.
      ud_dout_tvalid = (c == 3);
      ud_dout_tdata  = 64'h1234_5678_9ABC_DEF0;
      settle();
      n_vec++;
      if ({sd_dvd_tvalid, sd_dvs_tvalid, ud_dvd_tvalid, ud_dvs_tvalid, resp_valid, busy} !== 6'b000001) begin
        n_err++; $display("FAIL signed_wait c=%0d: got %b expected 000001", c,
                          {sd_dvd_tvalid, sd_dvs_tvalid, ud_dvd_tvalid, ud_dvs_tvalid, resp_valid, busy});
      end
      tick();
    end
    ud_dout_tvalid = 1'b0;
    sd_dout_tvalid = 1'b1;
    sd_dout_tdata  = {32'hFFFF_FFFD, 32'hFFFF_FFFF};
    tick();
    sd_dout_tvalid = 1'b0;
    sd_dout_tdata  = '0;
    settle();
    n_vec++;
    if ({resp_valid, resp_quot, resp_rem} !== {1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF}) begin
      n_err++; $display("FAIL signed_resp: got %b %h %h expected 1 fffffffd ffffffff", resp_valid, resp_quot, resp_rem);
    end
    tick();
    settle();
    n_vec++;
    if ({resp_valid, req_ready, busy} !== 3'b010) begin
      n_err++; $display("FAIL signed_retire: got %b expected 010", {resp_valid, req_ready, busy});
    end
  endtask

  task automatic test_unsigned();
    issue_req(1'b0, 32'hFFFF_FFFF, 32'h10);
    ud_dvd_tready = 1'b0; ud_dvs_tready = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      ud_dvd_tready = (c == 4);
      settle();
      n_vec++;
      if ({ud_dvd_tvalid, ud_dvs_tvalid, sd_dvd_tvalid, sd_dvs_tvalid} !== {1'b1, (c == 1), 2'b00}) begin
        n_err++; $display("FAIL unsigned_issue c=%0d: got %b expected %b", c,
                          {ud_dvd_tvalid, ud_dvs_tvalid, sd_dvd_tvalid, sd_dvs_tvalid}, {1'b1, (c == 1), 2'b00});
      end
      n_vec++;
      if (s_dvd_tdata !== 32'hFFFF_FFFF) begin
        n_err++; $display("FAIL unsigned_tdata c=%0d: got %h expected ffffffff", c, s_dvd_tdata);
      end
      tick();
    end
    settle();
    n_vec++;
    if ({ud_dvd_tvalid, ud_dvs_tvalid, busy} !== 3'b001) begin
      n_err++; $display("FAIL unsigned_wait: got %b expected 001", {ud_dvd_tvalid, ud_dvs_tvalid, busy});
    end
    ud_dout_tvalid = 1'b1;
    ud_dout_tdata  = {32'h0FFF_FFFF, 32'h0000_000F};
    tick();
    ud_dout_tvalid = 1'b0;
    settle();
    n_vec++;
    if ({resp_valid, resp_quot, resp_rem} !== {1'b1, 32'h0FFF_FFFF, 32'h0000_000F}) begin
      n_err++; $display("FAIL unsigned_resp: got %b %h %h expected 1 0fffffff 0000000f", resp_valid, resp_quot, resp_rem);
    end
    tick();
  endtask

  task automatic test_resp_hold();
    issue_req(1'b1, 32'd20, 32'd6);
    resp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    sd_dout_tvalid = 1'b1;
    sd_dout_tdata  = {32'd3, 32'd2};
    tick();
    sd_dout_tvalid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      // A waiting request must not be accepted while a result is held.
      issue_req(1'b0, 32'd77, 32'd7);
      req_valid  = (c < 6);
      resp_ready = (c == 6);
      settle();
      n_vec++;
      if ({resp_valid, req_ready, resp_quot, resp_rem} !== {2'b10, 32'd3, 32'd2}) begin
        n_err++; $display("FAIL hold c=%0d: got %b %b %h %h expected 1 0 00000003 00000002",
                          c, resp_valid, req_ready, resp_quot, resp_rem);
      end
      tick();
    end
    settle();
    n_vec++;
    if ({resp_valid, busy, req_ready} !== 3'b001) begin
      n_err++; $display("FAIL hold_retire: got %b expected 001", {resp_valid, busy, req_ready});
    end
  endtask

  task automatic test_flush_wait();
    issue_req(1'b1, 32'd50, 32'd5);
    sd_dvd_tready = 1'b1; sd_dvs_tready = 1'b1;
    resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    flush = 1'b1;
    settle();
    n_vec++;
    if (req_ready !== 1'b0) begin
      n_err++; $display("FAIL flush_wait_ready: got %b expected 0", req_ready);
    end
    tick();
    for (int c = 1; c <= 7; c++) begin
      // A second flush while draining is a no-op.
      flush = (c == 3);
      settle();
      n_vec++;
      if ({resp_valid, req_ready, busy} !== 3'b001) begin
        n_err++; $display("FAIL flush_drain c=%0d: got %b expected 001", c, {resp_valid, req_ready, busy});
      end
      tick();
    end
    flush = 1'b0;
    sd_dout_tvalid = 1'b1;
    sd_dout_tdata  = {32'hDEAD_0001, 32'hBEEF_0002};
    settle();
    n_vec++;
    if ({resp_valid, req_ready, busy} !== 3'b001) begin
      n_err++; $display("FAIL flush_dout_cycle: got %b expected 001", {resp_valid, req_ready, busy});
    end
    tick();
    sd_dout_tvalid = 1'b0;
    settle();
    n_vec++;
    if ({resp_valid, req_ready, busy, resp_quot, resp_rem} !== {3'b010, 32'd3, 32'd2}) begin
      n_err++; $display("FAIL flush_wait_end: got %b %h %h expected 010 00000003 00000002",
                        {resp_valid, req_ready, busy}, resp_quot, resp_rem);
    end
  endtask

  task automatic test_flush_issue();
    issue_req(1'b0, 32'd50, 32'd5);
    ud_dvd_tready = 1'b0; ud_dvs_tready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    flush = 1'b1;
    settle();
    n_vec++;
    if ({ud_dvd_tvalid, ud_dvs_tvalid, req_ready} !== 3'b100) begin
      n_err++; $display("FAIL flush_issue_c2: got %b expected 100", {ud_dvd_tvalid, ud_dvs_tvalid, req_ready});
    end
    tick();
    flush = 1'b0;
    settle();
    n_vec++;
    if ({ud_dvd_tvalid, ud_dvs_tvalid, busy} !== 3'b101) begin
      n_err++; $display("FAIL flush_issue_c3: got %b expected 101", {ud_dvd_tvalid, ud_dvs_tvalid, busy});
    end
    tick();
    ud_dvd_tready = 1'b1;
    settle();
    n_vec++;
    if (ud_dvd_tvalid !== 1'b1) begin
      n_err++; $display("FAIL flush_issue_c4: got %b expected 1", ud_dvd_tvalid);
    end
    tick();
    settle();
    n_vec++;
    if ({ud_dvd_tvalid, resp_valid, busy, req_ready} !== 4'b0010) begin
      n_err++; $display("FAIL flush_issue_drain: got %b expected 0010", {ud_dvd_tvalid, resp_valid, busy, req_ready});
    end
    tick();
    ud_dout_tvalid = 1'b1;
    ud_dout_tdata  = {32'd10, 32'd0};
    settle();
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL flush_issue_busy: got %b expected 1", busy);
    end
    tick();
    ud_dout_tvalid = 1'b0;
    settle();
    n_vec++;
    if ({resp_valid, busy, req_ready, resp_quot} !== {3'b001, 32'd3}) begin
      n_err++; $display("FAIL flush_issue_end: got %b %h expected 001 00000003", {resp_valid, busy, req_ready}, resp_quot);
    end
  endtask

  task automatic test_flush_abort();
    issue_req(1'b1, 32'd8, 32'd4);
    sd_dvd_tready = 1'b0; sd_dvs_tready = 1'b0;
    tick();
    req_valid = 1'b0;
    flush = 1'b1;
    settle();
    n_vec++;
    if ({sd_dvd_tvalid, sd_dvs_tvalid} !== 2'b11) begin
      n_err++; $display("FAIL abort_issue: got %b expected 11", {sd_dvd_tvalid, sd_dvs_tvalid});
    end
    tick();
    // Flush coinciding with a new request in IDLE: nothing is accepted.
    req_valid = 1'b1;
    settle();
    n_vec++;
    if ({sd_dvd_tvalid, sd_dvs_tvalid, busy, req_ready} !== 4'b0000) begin
      n_err++; $display("FAIL abort_idle: got %b expected 0000", {sd_dvd_tvalid, sd_dvs_tvalid, busy, req_ready});
    end
    tick();
    req_valid = 1'b0;
    flush = 1'b0;
    settle();
    n_vec++;
    if ({busy, req_ready, sd_dvd_tvalid} !== 3'b010) begin
      n_err++; $display("FAIL abort_no_accept: got %b expected 010", {busy, req_ready, sd_dvd_tvalid});
    end
    sd_dvd_tready = 1'b1; sd_dvs_tready = 1'b1;
  endtask

  task automatic test_back_to_back();
    ud_dvd_tready = 1'b1; ud_dvs_tready = 1'b1;
    resp_ready = 1'b1;
    issue_req(1'b1, 32'd100, 32'd7);
    tick();
    req_valid = 1'b0;
    tick();
    sd_dout_tvalid = 1'b1;
    sd_dout_tdata  = {32'd14, 32'd2};
    tick();
    sd_dout_tvalid = 1'b0;
    issue_req(1'b0, 32'd9, 32'd3);
    settle();
    n_vec++;
    if ({resp_valid, req_ready, resp_quot, resp_rem} !== {2'b10, 32'd14, 32'd2}) begin
      n_err++; $display("FAIL b2b_first: got %b %b %h %h expected 1 0 0000000e 00000002",
                        resp_valid, req_ready, resp_quot, resp_rem);
    end
    tick();
    settle();
    n_vec++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      n_err++; $display("FAIL b2b_accept: got %b expected 01", {resp_valid, req_ready});
    end
    tick();
    req_valid = 1'b0;
    settle();
    n_vec++;
    if ({ud_dvd_tvalid, ud_dvs_tvalid, sd_dvd_tvalid, s_dvd_tdata, s_dvs_tdata} !== {3'b110, 32'd9, 32'd3}) begin
      n_err++; $display("FAIL b2b_issue: got %b %h %h expected 110 00000009 00000003",
                        {ud_dvd_tvalid, ud_dvs_tvalid, sd_dvd_tvalid}, s_dvd_tdata, s_dvs_tdata);
    end
    tick();
    ud_dout_tvalid = 1'b1;
    ud_dout_tdata  = {32'd3, 32'd0};
    tick();
    ud_dout_tvalid = 1'b0;
    settle();
    n_vec++;
    if ({resp_valid, resp_quot, resp_rem} !== {1'b1, 32'd3, 32'd0}) begin
      n_err++; $display("FAIL b2b_second: got %b %h %h expected 1 00000003 00000000", resp_valid, resp_quot, resp_rem);
    end
    tick();
    settle();
    n_vec++;
    if ({resp_valid, busy} !== 2'b00) begin
      n_err++; $display("FAIL b2b_idle: got %b expected 00", {resp_valid, busy});
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_signed = 1'b0; req_src1 = '0; req_src2 = '0;
    flush = 1'b0; resp_ready = 1'b0;
    sd_dvd_tready = 1'b0; sd_dvs_tready = 1'b0; sd_dout_tvalid = 1'b0; sd_dout_tdata = '0;
    ud_dvd_tready = 1'b0; ud_dvs_tready = 1'b0; ud_dout_tvalid = 1'b0; ud_dout_tdata = '0;

    test_reset();
    test_signed();
    test_unsigned();
    test_resp_hold();
    test_flush_wait();
    test_flush_issue();
    test_flush_abort();
    test_back_to_back();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
Sequencing controller between the EX stage and the two divider IP cores (signed and unsigned), which have AXI-stream style operand channels.
- Accepts one divide request at a time over a valid/ready handshake.
- Drives the selected core's dividend and divisor channels independently.
- Captures the 64-bit core output and holds it until EX consumes it.
- On pipeline flush, abandons a request that has not been issued, or drains one already in flight.

Parameters:
DATA_W, 32, operand / quotient / remainder width

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
req_valid  in  1  EX presents a divide request
req_ready  out  1  controller accepts a request this cycle
req_signed  in  1  1 = signed core, 0 = unsigned core
req_src1  in  DATA_W  dividend (rj)
req_src2  in  DATA_W  divisor (rkd)
flush  in  1  cancel the current request (exception / branch flush)
resp_valid  out  1  result available
resp_ready  in  1  EX consumes the result
resp_quot  out  DATA_W  quotient
resp_rem  out  DATA_W  remainder
busy  out  1  state != IDLE
s_dvd_tdata  out  DATA_W  dividend data, shared by both cores
s_dvs_tdata  out  DATA_W  divisor data, shared by both cores
sd_dvd_tvalid / sd_dvd_tready  out / in  1  signed core, dividend channel
sd_dvs_tvalid / sd_dvs_tready  out / in  1  signed core, divisor channel
sd_dout_tvalid  in  1  signed core, result valid
sd_dout_tdata  in  2*DATA_W  signed core result, {quot, rem}
ud_* (same six signals)  —  unsigned core, identical meaning

Behaviour:
- Reset (synchronous): state = IDLE. All tvalid outputs, resp_valid and busy are 0. Operand, result and sel_signed registers are 0.
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- IDLE
  - req_ready = !flush.
  - Accept when req_valid & req_ready: latch src1, src2 and sel_signed; set dvd_pend = dvs_pend = 1; go to ISSUE.
  - flush and req_valid in the same cycle: flush wins, nothing is accepted.
- ISSUE
  - The selected core's dvd_tvalid = dvd_pend and dvs_tvalid = dvs_pend. The other core's tvalids stay 0.
  - A pend bit clears on tvalid & tready for its own channel.
  - The two channels complete independently, in any order, possibly in the same cycle.
  - tdata stays stable while its tvalid is high.
  - When both pend bits are clear (including the cycle the last one clears), go to WAIT.
  - Flush with both pend bits still set: deassert both tvalids next cycle and go to IDLE.
  - Flush with exactly one pend bit set: set the flushed flag, keep issuing the remaining channel (a core cannot be left with one operand), then go to DRAIN instead of WAIT.
- WAIT
  - On the selected core's dout_tvalid, capture {quot, rem} (upper half = quotient) and go to DONE.
  - dout_tvalid from the non-selected core is ignored.
  - Flush: go to DRAIN. A flush in the same cycle as dout_tvalid discards the result and goes to IDLE.
- DONE
  - resp_valid = 1. resp_quot and resp_rem are stable registers.
  - resp_valid & resp_ready: go to IDLE. resp_ready arriving with flush counts as consumed; either way go to IDLE.
  - Flush without resp_ready: go to IDLE, result dropped.
  - resp_valid never asserts in a flushed transaction.
- DRAIN
  - resp_valid = 0, req_ready = 0.
  - On the selected core's dout_tvalid, discard the result and go to IDLE.
  - Further flush inputs have no effect.
- Latency
  - Accept to ISSUE: 1 cycle.
  - ISSUE with both tready high: 1 cycle.
  - dout_tvalid to resp_valid: 1 cycle.
  - Back-to-back requests: a new accept is possible in the cycle after DONE retires.
- Divide by zero is not special-cased; the core's output is passed through unchanged.

Decomposition:
- Shared package div_ctrl_pkg:
  - DATA_W default.
  - State enumeration (one-hot, 5 bits).
  - Result field slicing constants (QUOT_MSB/LSB, REM_MSB/LSB).
- One natural sub-module, axis_src_hold: one channel's pend bit plus tvalid generation. Instantiated twice (dividend, divisor). Inputs: start, tready, enable. Outputs: tvalid, done.

Test Plan:
- Signed, src1 = 0xFFFFFFF9 (-7), src2 = 2, both treadys high, resp_ready high, core dout after 10 cycles -> resp_quot = 0xFFFFFFFD, resp_rem = 0xFFFFFFFF; resp_valid high exactly 1 cycle; ud_* tvalids stay 0.
- Unsigned, 0xFFFFFFFF / 0x10; ud_dvd_tready held low 3 cycles, ud_dvs_tready high -> dvs tvalid drops after cycle 1, dvd tvalid held 4 cycles with tdata stable; resp_quot = 0x0FFFFFFF, resp_rem = 0xF.
- resp_ready held low 5 cycles in DONE -> resp_valid and data stable for 6 cycles; req_ready = 0 throughout.
- Flush in WAIT, core dout 8 cycles later -> state DRAIN, resp_valid never asserts, req_ready = 0 until the cycle after dout_tvalid, then 1.
- Flush in ISSUE after divisor accepted, dividend tready low -> dividend tvalid stays high until accepted, then DRAIN; result discarded; busy falls after dout_tvalid.
- Two back-to-back requests (signed 100/7, then unsigned 9/3) -> results {14, 2} then {3, 0}; second accept occurs in the cycle after the first result retires.
